// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM encoding and alignment helper for the LSU.
// Imported by load_store_unit and load_extend.
package load_store_unit_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

   localparam logic [1:0] RS_LOAD = 2'b01;

   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_DONE   = 2'b10
   } state_t;

   // Undefined codes fall into the trap path too.
   function automatic logic is_bad(
      input logic       st,
      input logic [1:0] sc,
      input logic [2:0] lc,
      input logic [1:0] off
   );
      logic bad;
      bad = 1'b1;
      if (st) begin
         case (sc)
            ST_SB:   bad = 1'b0;
            ST_SH:   bad = off[0];
            ST_SW:   bad = |off;
            default: bad = 1'b1;
         endcase
      end else begin
         case (lc)
            LD_LB,
            LD_LBU:  bad = 1'b0;
            LD_LH,
            LD_LHU:  bad = off[0];
            LD_LW:   bad = |off;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane select and sign/zero extension (combinational).
// Ports: rdata (memory word), off (byte offset), ld (load code) -> data.
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  ld,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = 8'(rdata >> {off, 3'b000});
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (ld)
         LD_LB:   data = {{24{b[7]}}, b};
         LD_LH:   data = {{16{h[15]}}, h};
         LD_LW:   data = rdata;
         LD_LBU:  data = {24'h0, b};
         LD_LHU:  data = {16'h0, h};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/ACCESS/DONE handshake to data memory.
// Core side: MemWrite/ResultSrc/Store/Load/ALUResult/WriteData in; ReadData/Stall/misaligned/timeout out. Memory side: dmem_* req/ack.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [1:0]  ResultSrc,
   input  logic [1:0]  Store,
   input  logic [2:0]  Load,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        misaligned,
   output logic        timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rd_q, rd_d;
   logic [1:0]    off_q, off_d;
   logic [2:0]    ld_q, ld_d;
   logic          mis_q, mis_d;
   logic          to_q, to_d;

   logic          pending;
   logic          bad;
   logic          cnt_hit;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;
   logic [31:0]   ld_data;

   assign pending = MemWrite | (ResultSrc == RS_LOAD);
   assign bad     = is_bad(MemWrite, Store, Load, ALUResult[1:0]);
   assign cnt_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   load_extend u_ext (
      .rdata (dmem_rdata),
      .off   (off_q),
      .ld    (ld_q),
      .data  (ld_data)
   );

   always_comb begin
      case (Store)
         ST_SB: begin
            be_n    = 4'b0001 << ALUResult[1:0];
            wdata_n = {4{WriteData[7:0]}};
         end
         ST_SH: begin
            be_n    = ALUResult[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{WriteData[15:0]}};
         end
         default: begin
            be_n    = 4'b1111;
            wdata_n = WriteData;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (pending) state_d = bad ? S_DONE : S_ACCESS;
         S_ACCESS: if (dmem_ack || cnt_hit) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dmem_req = (state_q == S_ACCESS);
      Stall    = pending && (state_q != S_DONE);
   end

   assign dmem_we    = we_q;
   assign dmem_be    = be_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign ReadData   = rd_q;
   assign misaligned = mis_q;
   assign timeout    = to_q;

   always_comb begin
      cnt_d   = cnt_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      off_d   = off_q;
      ld_d    = ld_q;
      mis_d   = mis_q;
      to_d    = to_q;
      case (state_q)
         S_IDLE: begin
            if (pending && bad) begin
               mis_d = 1'b1;
               rd_d  = '0;
            end else if (pending) begin
               cnt_d   = '0;
               we_d    = MemWrite;
               be_d    = MemWrite ? be_n : 4'b1111;
               addr_d  = {ALUResult[31:2], 2'b00};
               wdata_d = MemWrite ? wdata_n : '0;
               off_d   = ALUResult[1:0];
               ld_d    = Load;
            end
         end
         S_ACCESS: begin
            // Ack beats a timeout landing on the same cycle.
            if (dmem_ack) begin
               we_d = 1'b0;
               be_d = '0;
               if (!we_q) rd_d = ld_data;
            end else if (cnt_hit) begin
               we_d = 1'b0;
               be_d = '0;
               to_d = 1'b1;
               if (!we_q) rd_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            mis_d = 1'b0;
            to_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         off_q   <= '0;
         ld_q    <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         off_q   <= off_d;
         ld_q    <= ld_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
      end
   end

endmodule
